alu_seq_param: RTL
==================

# alu_seq_param

Parametrised, registered successor to the team's 8-bit combinational ALU. Takes two WIDTH-bit unsigned operands and a 3-bit opcode under a Start/Busy/Done handshake and returns a 2×WIDTH result split into high and low words (YH/YL). Bitwise, add, subtract and compare complete in one cycle. Multiply (shift-add) and divide (restoring) run iteratively over WIDTH cycles. It sits between the VIO/host stimulus and downstream logic, in place of the combinational ALU.

## Interface
- WIDTH, 8, operand and result-word width; legal range 4–32.
- Clk  in  1  rising-edge clock; the only clock.
- Rst_n  in  1  reset; synchronous, active-low.
- Start  in  1  request; sampled only when Busy=0.
- S  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 CMP.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- YH  out  WIDTH  result high word, registered.
- YL  out  WIDTH  result low word, registered.
- Busy  out  1  high while a MUL or DIV is in progress.
- Done  out  1  one-cycle pulse when YH/YL/Err are updated.
- Err  out  1  set with Done for DIV by zero; otherwise 0.

## Operation
- FSM states: IDLE, RUN.
- **Start acceptance:** Start is accepted at a rising edge only if the state is IDLE and Rst_n=1. S, A and B are captured at that edge.
- **Single-cycle ops (S=0,1,4,5,6,7):** results are written at the accepting edge. The FSM stays in IDLE.
  - ADD: YL = (A+B) mod 2^WIDTH; YH = {0…, carry}.
  - SUB: YL = (A−B) mod 2^WIDTH; YH = {0…, borrow}, where borrow = A<B.
  - AND / OR / XOR: YL = bitwise result; YH = 0.
  - CMP: YL[0] = A<B, YL[1] = A==B, YL[2] = A>B, other bits 0; YH = 0.
- **MUL (S=2), IDLE→RUN:**
  - Shift-add over WIDTH iterations using a 2×WIDTH accumulator.
  - Final result {YH,YL} = A*B, exact, unsigned.
- **DIV (S=3), IDLE→RUN:**
  - Restoring division over WIDTH iterations.
  - YL = quotient, YH = remainder.
  - If B==0: no iteration is meaningful, but the FSM still runs the full WIDTH cycles so latency stays uniform. Result: YL = all ones, YH = A, Err = 1.
- **RUN state:** an iteration counter of width clog2(WIDTH+1) counts 1..WIDTH. At count WIDTH, the result is written, Done pulses, and the FSM goes RUN→IDLE.
- **Output hold:** YH, YL and Err hold their last values until the next write. Err is rewritten on every Done: 1 only for DIV-by-zero.
- **Start while Busy:** ignored entirely. It is not queued and the opcode is not re-sampled.
- **Opcode and operand stability:** S, A and B may change freely after the accepting edge; the internal copies are used.

## Timing
- **Reset:** at any edge with Rst_n=0, state = IDLE, counter = 0, and YH = YL = 0, Busy = 0, Done = 0, Err = 0. This applies mid-RUN as well: the operation is aborted, no Done is issued, and no partial result appears.
- **Single-cycle op accepted at edge k:**
  - YH/YL/Err are valid and Done=1 during cycle k→k+1.
  - Busy stays 0.
  - Back-to-back Starts give one Done per cycle.
- **MUL/DIV accepted at edge k:**
  - Busy=1 from edge k.
  - Iterations run at edges k+1…k+WIDTH.
  - At edge k+WIDTH: result is written, Done=1 for one cycle, Busy=0.
  - Latency is WIDTH cycles.
- **Start held high at edge k+WIDTH:** ignored, because Busy was 1 when sampled. The earliest new acceptance is edge k+WIDTH+1.
- **Done** is never high for more than one consecutive cycle during a multi-cycle op. It is high on consecutive cycles only for consecutive single-cycle ops.
- **Busy and Done** are never both 1.

## Test plan
All scenarios use WIDTH=8.
- **Reset values:** hold Rst_n=0 for 2 edges, release.
  - Response: YH=YL=0x00, Busy=Done=Err=0.
- **ADD, then SUB back-to-back:** ADD A=200, B=100 on one cycle; SUB A=5, B=9 on the next cycle.
  - ADD: YL=0x2C, YH=0x01, Done=1 after the first edge.
  - SUB: YL=0xFC, YH=0x01, Done=1 after the next edge. Busy stays 0 throughout.
- **MUL:** A=255, B=255, S=2, accepted at edge k.
  - Busy=1 over edges k…k+7.
  - At edge k+8: YH=0xFE, YL=0x01, a single Done pulse, Busy=0.
  - A Start held high throughout is ignored until edge k+9.
- **DIV, normal and divide-by-zero:**
  - A=200, B=7: after 8 cycles, YL=0x1C, YH=0x04, Err=0.
  - A=0x5A, B=0: after 8 cycles, YL=0xFF, YH=0x5A, Err=1.
  - A following ADD: Err returns to 0.
- **Reset mid-operation:** start MUL A=3, B=4; assert Rst_n=0 at edge k+4.
  - Response: Busy=0, no Done, YH=YL=0.
  - A fresh MUL then yields YL=0x0C, YH=0x00.
- **CMP sweep:**
  - A=10, B=20 → YL=0x01.
  - A=B=7 → YL=0x02.
  - A=0xFF, B=0 → YL=0x04.
  - YH=0 in all three cases.

Source files
------------

// File: rtl/alu_seq_param.sv
// Registered ALU: ADD/SUB/AND/OR/XOR/CMP finish at the accepting edge, MUL/DIV take WIDTH cycles.
// Start is sampled only while idle; a Start seen while Busy is dropped, never queued.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] YH,
  output logic [WIDTH-1:0] YL,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   sc_hi;
  logic [WIDTH-1:0]   sc_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_take;

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];

  // Single-cycle results, computed straight from the live inputs
  always_comb begin
    add_w = {1'b0, A} + {1'b0, B};
    sub_w = {1'b0, A} - {1'b0, B};
    sc_hi = '0;
    sc_lo = '0;
    case (S)
      OP_ADD: begin
        sc_lo    = add_w[WIDTH-1:0];
        sc_hi[0] = add_w[WIDTH];
      end
      OP_SUB: begin
        sc_lo    = sub_w[WIDTH-1:0];
        sc_hi[0] = sub_w[WIDTH];
      end
      OP_AND: sc_lo = A & B;
      OP_OR:  sc_lo = A | B;
      OP_XOR: sc_lo = A ^ B;
      OP_CMP: begin
        sc_lo[0] = (A < B);
        sc_lo[1] = (A == B);
        sc_lo[2] = (A > B);
      end
      default: ;
    endcase
  end

  // One iteration. MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}.
  // A set top bit in the shifted remainder means it already exceeds any divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, a_r};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_take  = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= b_r);
    div_diff  = div_shift[WIDTH-1:0] - b_r;
    if (op_r == OP_MUL) begin
      if (acc_lo[0]) acc_nxt = {mul_sum, acc_lo[WIDTH-1:1]};
      else           acc_nxt = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end else begin
      acc_nxt = {(div_take ? div_diff : div_shift[WIDTH-1:0]), acc_lo[WIDTH-2:0], div_take};
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= OP_ADD;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      YH    <= '0;
      YL    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            op_r <= S;
            a_r  <= A;
            b_r  <= B;
            cnt  <= '0;
            if (S == OP_MUL || S == OP_DIV) begin
              state <= RUN;
              Busy  <= 1'b1;
              acc   <= (S == OP_MUL) ? {{WIDTH{1'b0}}, B} : {{WIDTH{1'b0}}, A};
            end else begin
              YH   <= sc_hi;
              YL   <= sc_lo;
              Err  <= 1'b0;
              Done <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_M1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            cnt   <= '0;
            // Divide-by-zero still runs the full count so latency never depends on data
            if (op_r == OP_DIV && b_r == '0) begin
              YH  <= a_r;
              YL  <= '1;
              Err <= 1'b1;
            end else begin
              YH  <= acc_nxt[2*WIDTH-1:WIDTH];
              YL  <= acc_nxt[WIDTH-1:0];
              Err <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
